// File: rtl/t_integrator_pkg.sv
// Shared types and constants for the slope integrator: Q7.0 samples and the
// Q8.FRAC_W fractional accumulator.
package tint_pkg;

    localparam int FRAC_W = 15;
    localparam int K_MAX  = 15;
    localparam int ACC_W  = 8 + FRAC_W;
    localparam int SH_W   = $clog2(K_MAX + 1);

    typedef logic signed [7:0]       q7_0_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/t_integrator_if.sv
// Streaming bus of the integrator: dT samples in, clamped temperature out.
interface t_integrator_if;
    import tint_pkg::*;

    logic  in_valid;
    logic  in_ready;
    q7_0_t dT_in;
    logic  out_valid;
    logic  out_ready;
    q7_0_t T_out;
    logic  sat_hi;
    logic  sat_lo;

    modport master (
        output in_valid, dT_in, out_ready,
        input  in_ready, out_valid, T_out, sat_hi, sat_lo
    );

    modport slave (
        input  in_valid, dT_in, out_ready,
        output in_ready, out_valid, T_out, sat_hi, sat_lo
    );

endinterface

// File: rtl/t_integrator_sat_add.sv
// Combinational scaled add of one dT sample into the accumulator, followed by
// a two-sided clamp (upper bound first, lower bound wins when inverted).
module tint_sat_add
    import tint_pkg::*;
(
    input  acc_t       acc_i,
    input  q7_0_t      dT_i,
    input  logic [7:0] k_dt_i,
    input  q7_0_t      t_min_i,
    input  q7_0_t      t_max_i,
    output acc_t       acc_o,
    output logic       sat_hi_o,
    output logic       sat_lo_o
);

    typedef logic signed [ACC_W:0] wide_t;

    logic [SH_W-1:0] shift;
    acc_t            incRaw;
    acc_t            inc;
    wide_t           sum;
    wide_t           hiBound;
    wide_t           loBound;
    wide_t           clipped;

    // One extra bit on the sum so the clamp sees true overflow rather than wrap.
    always_comb begin
        shift    = (k_dt_i > 8'(K_MAX)) ? SH_W'(K_MAX) : k_dt_i[SH_W-1:0];
        incRaw   = {dT_i, {FRAC_W{1'b0}}};
        inc      = incRaw >>> shift;
        sum      = {acc_i[ACC_W-1], acc_i} + {inc[ACC_W-1], inc};
        hiBound  = {t_max_i[7], t_max_i, {FRAC_W{1'b1}}};
        loBound  = {t_min_i[7], t_min_i, {FRAC_W{1'b0}}};
        clipped  = sum;
        sat_hi_o = 1'b0;
        sat_lo_o = 1'b0;
        if (clipped > hiBound) begin
            clipped  = hiBound;
            sat_hi_o = 1'b1;
        end
        if (clipped < loBound) begin
            clipped  = loBound;
            sat_lo_o = 1'b1;
        end
        acc_o = acc_t'(clipped);
    end

endmodule

// File: rtl/t_integrator.sv
// Integrates a Q7.0 slope stream into a clamped temperature trajectory.
// Optional macro TINT_ROUND_EN: T_out rounds half-up instead of flooring.
module t_integrator
    import tint_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init_i,
    input  q7_0_t          T_init_i,
    input  logic [7:0]     k_dt_i,
    input  q7_0_t          t_min_i,
    input  q7_0_t          t_max_i,
    t_integrator_if.slave  bus
);

    state_e state_q, state_d;
    acc_t   acc_q, acc_d, accSum;
    q7_0_t  tout_q, tout_d, toutSum, initClamped;
    logic   outValid_q, outValid_d;
    logic   satHi_q, satHi_d, satLo_q, satLo_d;
    logic   addHi, addLo, inReady, accept;
`ifdef TINT_ROUND_EN
    logic signed [8:0] rounded;
`endif

    tint_sat_add uSatAdd (
        .acc_i    (acc_q),
        .dT_i     (bus.dT_in),
        .k_dt_i   (k_dt_i),
        .t_min_i  (t_min_i),
        .t_max_i  (t_max_i),
        .acc_o    (accSum),
        .sat_hi_o (addHi),
        .sat_lo_o (addLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            tout_q     <= '0;
            outValid_q <= 1'b0;
            satHi_q    <= 1'b0;
            satLo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tout_q     <= tout_d;
            outValid_q <= outValid_d;
            satHi_q    <= satHi_d;
            satLo_q    <= satLo_d;
        end
    end

    // init outranks everything; its reload is never presented as valid output.
    always_comb begin
        inReady = (state_q == RUN) && (!outValid_q || bus.out_ready) && !init_i;
        accept  = bus.in_valid && inReady;

        initClamped = T_init_i;
        if (initClamped > t_max_i) initClamped = t_max_i;
        if (initClamped < t_min_i) initClamped = t_min_i;

`ifdef TINT_ROUND_EN
        rounded = {accSum[ACC_W-1], accSum[ACC_W-1:FRAC_W]} + {8'b0, accSum[FRAC_W-1]};
        toutSum = (rounded > 9'sd127) ? 8'sd127 : q7_0_t'(rounded[7:0]);
`else
        toutSum = accSum[ACC_W-1:FRAC_W];
`endif

        state_d    = state_q;
        acc_d      = acc_q;
        tout_d     = tout_q;
        outValid_d = outValid_q;
        satHi_d    = satHi_q;
        satLo_d    = satLo_q;

        if (init_i) begin
            state_d    = RUN;
            acc_d      = {initClamped, {FRAC_W{1'b0}}};
            tout_d     = initClamped;
            outValid_d = 1'b0;
            satHi_d    = 1'b0;
            satLo_d    = 1'b0;
        end else if (accept) begin
            acc_d      = accSum;
            tout_d     = toutSum;
            outValid_d = 1'b1;
            satHi_d    = addHi;
            satLo_d    = addLo;
        end else if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.T_out     = tout_q;
    assign bus.sat_hi    = satHi_q;
    assign bus.sat_lo    = satLo_q;

endmodule

// File: doc/t_integrator.md
Name: t_integrator

Overview:
- Inverse of the dT estimator: integrates a signed Q7.0 slope stream dT[n] into a temperature trajectory T[n] = T[n-1] + dT[n]/2^k.
- Used as a reference/setpoint ramp generator and as a closed-loop checker that rebuilds T from estimated dT.
- Fractional accumulator (Q8.15) with min/max clamp, valid/ready handshake on input and output, INIT reload without output spike.

Parameters:
- FRAC_W, 15, fractional bits of the accumulator (accumulator width = 8+FRAC_W).
- K_MAX, 15, largest honoured k_dt; larger values are clamped to K_MAX.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init  in  1  1-cycle pulse: load accumulator from T_init, enter RUN
- T_init  in  8  signed Q7.0 start value
- k_dt  in  8  slope divider exponent (dT/2^k)
- t_min  in  8  signed Q7.0 lower clamp
- t_max  in  8  signed Q7.0 upper clamp
- in_valid  in  1  dT_in valid
- in_ready  out  1  block accepts dT_in
- dT_in  in  8  signed Q7.0 slope sample
- out_valid  out  1  T_out valid
- out_ready  in  1  downstream accepts T_out
- T_out  out  8  signed Q7.0 integrated temperature
- sat_hi  out  1  this sample clamped at t_max
- sat_lo  out  1  this sample clamped at t_min

Behaviour:
- Reset: state=IDLE, acc=0, T_out=0, out_valid=0, sat_hi=sat_lo=0. in_ready=0 (combinational).
- States: IDLE -> RUN on init. RUN -> RUN on init (reload). No other transitions; only reset returns to IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !init.
- Accept = in_valid && in_ready. On accept:
  - inc = sign-extend(dT_in) << FRAC_W, then arithmetic shift right by min(k_dt, K_MAX).
  - sum = acc + inc, computed one bit wider than acc; no wrap.
  - Clamp: hi = {t_max, all-ones frac}, lo = {t_min, zero frac}. First clip to hi, then to lo. If t_min > t_max, lo wins.
  - acc <= clamped sum; T_out <= acc_next[integer part] (floor); sat_hi/sat_lo register whether each clip fired.
  - out_valid <= 1. Latency: 1 cycle from accept to out_valid.
- Output handshake: out_valid clears on out_valid && out_ready when there is no simultaneous accept. Accept plus drain in the same cycle keeps out_valid=1 with the new data. T_out and flags are stable while out_valid && !out_ready.
- init (highest priority, any state):
  - acc <= {T_init clamped to [t_min, t_max], zero frac}.
  - out_valid <= 0; flags <= 0; T_out <= clamped T_init (not presented as valid, so no spike).
  - An in_valid in the init cycle is not accepted.
- Clamp bounds and k_dt are sampled at each accept; changing them between samples is legal.
- Async reset mid-operation returns to the reset values immediately; any pending output is dropped.

Optional Feature:
- TINT_ROUND_EN.
- Defined: T_out = round-half-up of acc (add 2^(FRAC_W-1) before truncation), saturated at +127. sat flags are unaffected.
- Undefined: T_out = floor(acc).

Decomposition:
- Package tint_pkg:
  - typedef q7_0_t (signed 8).
  - typedef acc_t (signed 8+FRAC_W).
  - state_e {IDLE, RUN}.
  - Constants FRAC_W, K_MAX.
- Sub-module tint_sat_add: combinational scaled add + two-sided clamp + flag generation. t_integrator keeps FSM, handshake and registers.

Test Plan:
- Reset with no init, in_valid=1 -> in_ready=0, out_valid=0, T_out=0 throughout.
- init T_init=20, bounds [-40,100], k=0, out_ready=1, dT=+3 x3 -> T_out 20+3=23, 26, 29, each 1 cycle after accept; no sat flags.
- init 20, k=2, dT=+1 x4 -> floor build: 20, 20, 20, 21. With TINT_ROUND_EN: 20, 21, 21, 21.
- Saturation, bounds [-40,100]:
  - From 98, dT=+5 -> 100, sat_hi=1.
  - Then dT=-128 -> -28.
  - Then dT=-128 -> -40, sat_lo=1.
  - Then bounds t_min=50, t_max=10, dT=0 -> 50.
- Backpressure: out_ready=0 after one output -> in_ready=0, T_out held 5 cycles. Then out_ready=1 with in_valid=1 in the same cycle -> next value follows, out_valid stays 1.
- Mid-stream reinit: out_valid=1 pending, init with T_init=-10 -> out_valid=0 next cycle, new accept dT=+2 (k=0) -> T_out=-8.
